// File: rtl/audioplay_audio_pkg.sv
// Shared audio constants and sample type for the audioplay I2S path.
package audioplay_audio_pkg;
  localparam int AUDIO_DATA_W   = 24;
  localparam int AUDIO_SLOT_W   = 32;
  localparam int AUDIO_BCLK_DIV = 4;

  typedef logic [AUDIO_DATA_W-1:0] audio_sample_t;
endpackage

// File: rtl/audioplay_sync2.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
module audioplay_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/audioplay_i2s_tx.sv
// I2S transmit serializer clocked by the 12.288 MHz audio PLL clock.
// Optional macro AUDIO_I2S_TX_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module audioplay_i2s_tx
  import audioplay_audio_pkg::*;
#(
  parameter int DATA_W   = AUDIO_DATA_W,
  parameter int BCLK_DIV = AUDIO_BCLK_DIV,
  parameter int SLOT_W   = AUDIO_SLOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrck,
  output logic              i2s_dout,
  output logic              frame_tick,
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_cnt,
`endif
  output logic              underrun
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(2 * SLOT_W);

  logic                  locked_s;
  logic                  run;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [BIT_W-1:0]      slot_pos;
  logic [2*DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]     hold_l;
  logic [DATA_W-1:0]     hold_r;
  logic                  full;
  logic                  div_wrap;
  logic                  bit_last;
  logic                  frame_load;
  logic                  data_pos;
  logic                  xfer;

  audioplay_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign run = enable & locked_s;

  // Counters sit at zero while idle, so the first run cycle and every
  // bit_cnt wrap both look like "counters at zero" and share one load term.
  always_comb begin
    div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    bit_last   = (bit_cnt == BIT_W'(2 * SLOT_W - 1));
    frame_load = run & (div_cnt == '0) & (bit_cnt == '0);
    slot_pos   = (bit_cnt >= BIT_W'(SLOT_W)) ? bit_cnt - BIT_W'(SLOT_W) : bit_cnt;
    data_pos   = (slot_pos >= BIT_W'(1)) && (slot_pos <= BIT_W'(DATA_W));
    xfer       = s_valid & ~full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_dout   <= 1'b0;
      frame_tick <= 1'b0;
    end else if (!run) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      i2s_bclk   <= 1'b0;
      i2s_lrck   <= 1'b0;
      i2s_dout   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) bit_cnt <= bit_last ? '0 : bit_cnt + BIT_W'(1);
      i2s_bclk   <= (div_cnt >= DIV_W'(BCLK_DIV / 2));
      i2s_lrck   <= (bit_cnt >= BIT_W'(SLOT_W));
      i2s_dout   <= data_pos & shift_reg[2*DATA_W-1];
      frame_tick <= frame_load;
      // Shift on the BCLK falling edge that ends each data position; the
      // left payload drains first so the right MSB is on top at its slot.
      if (frame_load) shift_reg <= full ? {hold_l, hold_r} : '0;
      else if (div_wrap && data_pos) shift_reg <= {shift_reg[2*DATA_W-2:0], 1'b0};
    end
  end

  // Handshake: a sample pair transfers on any clk edge where s_valid and
  // s_ready are both high; s_ready is simply the holding register being empty.
  assign s_ready = ~full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      hold_l   <= '0;
      hold_r   <= '0;
      underrun <= 1'b0;
    end else begin
      if (xfer) begin
        full   <= 1'b1;
        hold_l <= s_left;
        hold_r <= s_right;
      end else if (frame_load && full) begin
        full <= 1'b0;
      end
      if (!enable) underrun <= 1'b0;
      else if (frame_load && !full) underrun <= 1'b1;
    end
  end

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) underrun_cnt <= '0;
    else if (!enable) underrun_cnt <= '0;
    else if (frame_load && !full && underrun_cnt != 16'hFFFF)
      underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_audioplay_i2s_tx.sv
// Directed bench for audioplay_i2s_tx: reset, play, starvation, race, lock loss, back-pressure.
`timescale 1ns/1ps
module tb_audioplay_i2s_tx;
  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_left;
  logic [23:0] s_right;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_dout;
  logic        frame_tick;
  logic        underrun;
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int          vectors;
  int          miscompares;
  int          cyc;
  int          last_xfer_cyc;
  int          tick_cyc;
  bit          auto_src;
  logic [23:0] next_val;
  logic [47:0] exp_q[$];
  logic [47:0] exp_w;

  audioplay_i2s_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .enable     (enable),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_left     (s_left),
    .s_right    (s_right),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_dout   (i2s_dout),
    .frame_tick (frame_tick),
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .underrun   (underrun)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #40 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clk cycle; records a transfer on the edge where valid & ready held.
  task automatic step();
    logic acc;
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      exp_q.push_back({s_left, s_right});
      last_xfer_cyc = cyc;
      if (auto_src) begin
        next_val = next_val + 24'd1;
        s_left   = next_val;
        s_right  = ~next_val;
      end
    end
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check({tag, " tick"}, frame_tick, 1);
  endtask

  function automatic logic exp_bit(input int b, input logic [23:0] l, input logic [23:0] r);
    if (b >= 1 && b <= 24) return l[24-b];
    if (b >= 33 && b <= 56) return r[56-b];
    return 1'b0;
  endfunction

  // Called at the sample right after a frame load; ends 255 cycles later.
  task automatic check_frame(input logic [23:0] l, input logic [23:0] r, input string tag);
    int b;
    check({tag, " bclk0"}, i2s_bclk, 0);
    check({tag, " lrck0"}, i2s_lrck, 0);
    check({tag, " dout0"}, i2s_dout, 0);
    for (int m = 1; m < 256; m++) begin
      step();
      if (m % 4 == 2) begin
        b = m / 4;
        check($sformatf("%s bclk b%0d", tag, b), i2s_bclk, 1);
        check($sformatf("%s lrck b%0d", tag, b), i2s_lrck, (b >= 32) ? 1 : 0);
        check($sformatf("%s dout b%0d", tag, b), i2s_dout, exp_bit(b, l, r));
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; last_xfer_cyc = -1; auto_src = 0;
    next_val = 24'h0;
    rst_n = 1'b0; enable = 1'b0; pll_locked = 1'b0;
    s_valid = 1'b1; s_left = 24'hA5A5A5; s_right = 24'h5A5A5A;

    // reset
    repeat (3) begin @(posedge clk); #1; end
    check("rst bclk", i2s_bclk, 0);
    check("rst lrck", i2s_lrck, 0);
    check("rst dout", i2s_dout, 0);
    check("rst tick", frame_tick, 0);
    check("rst underrun", underrun, 0);
    check("rst s_ready", s_ready, 1);
    rst_n = 1'b1;
    step();
    s_valid = 1'b0;
    check("accept s_ready", s_ready, 0);
    check("accept count", exp_q.size(), 1);

    // normal play
    pll_locked = 1'b1; enable = 1'b1;
    wait_tick("play");
    check("play underrun", underrun, 0);
    check("play s_ready", s_ready, 1);
    exp_w = exp_q.pop_front();
    check_frame(exp_w[47:24], exp_w[23:0], "play");
    step();
    check("frame period tick", frame_tick, 1);
    check("empty underrun", underrun, 1);
    check_frame(24'h0, 24'h0, "empty");

    // starvation
    enable = 1'b0;
    step(); step();
    check("disable underrun clr", underrun, 0);
    check("disable bclk", i2s_bclk, 0);
    enable = 1'b1;
    wait_tick("starve");
    check("starve underrun", underrun, 1);
    check_frame(24'h0, 24'h0, "starve");
    for (int f = 0; f < 3; f++) begin
      step();
      check($sformatf("starve tick %0d", f + 2), frame_tick, 1);
      repeat (255) step();
    end
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt", underrun_cnt, 4);
`endif

    // boundary race: transfer lands on the frame-load edge
    enable = 1'b0;
    step(); step();
    enable = 1'b1; s_valid = 1'b1; s_left = 24'hC0FFEE; s_right = 24'h123456;
    step();
    s_valid = 1'b0;
    check("race tick", frame_tick, 1);
    check("race underrun", underrun, 1);
    check("race s_ready", s_ready, 0);
    check_frame(24'h0, 24'h0, "race zeros");
    step();
    check("race next tick", frame_tick, 1);
    exp_w = exp_q.pop_front();
    check_frame(exp_w[47:24], exp_w[23:0], "race held");

    // lock loss at bit 40
    step();
    check("loss frame tick", frame_tick, 1);
    s_valid = 1'b1; s_left = 24'hDEADBE; s_right = 24'h0BEEF0;
    step();
    s_valid = 1'b0;
    check("loss prefill s_ready", s_ready, 0);
    repeat (159) step();
    check("pre-loss lrck", i2s_lrck, 1);
    pll_locked = 1'b0;
    repeat (3) step();
    check("loss bclk", i2s_bclk, 0);
    check("loss lrck", i2s_lrck, 0);
    check("loss dout", i2s_dout, 0);
    check("loss tick", frame_tick, 0);
    check("loss held", s_ready, 0);
    repeat (5) step();
    pll_locked = 1'b1;
    wait_tick("relock");
    check("relock s_ready", s_ready, 1);
    exp_w = exp_q.pop_front();
    check_frame(exp_w[47:24], exp_w[23:0], "relock");

    // back-pressure
    auto_src = 1'b1; next_val = 24'h100000;
    s_left = next_val; s_right = ~next_val; s_valid = 1'b1;
    step();
    check("bp first tick", frame_tick, 1);
    check("bp first xfer", last_xfer_cyc, cyc);
    check_frame(24'h0, 24'h0, "bp zeros");
    for (int f = 0; f < 3; f++) begin
      step();
      check($sformatf("bp tick %0d", f), frame_tick, 1);
      tick_cyc = cyc;
      exp_w = exp_q.pop_front();
      check_frame(exp_w[47:24], exp_w[23:0], $sformatf("bp%0d", f));
      check($sformatf("bp xfer cyc %0d", f), last_xfer_cyc, tick_cyc + 1);
      check($sformatf("bp depth %0d", f), exp_q.size(), 1);
    end
    s_valid = 1'b0; auto_src = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/audioplay_i2s_tx.md
# audioplay_i2s_tx

I2S transmit serializer running directly on the 12.288 MHz audio clock produced by the audio PLL. It derives BCLK (3.072 MHz) and LRCK (48 kHz) from that clock. It accepts stereo 24-bit samples through a valid/ready handshake into a one-entry holding register, and shifts them out MSB-first in standard I2S format to the codec. Output generation is held idle until the PLL reports lock.

## Interface
Parameters:
- DATA_W, 24: sample width per channel.
- BCLK_DIV, 4: clk cycles per BCLK period; even, ≥2.
- SLOT_W, 32: BCLK periods per channel slot; must be > DATA_W.

Ports:
- clk  in  1  audio master clock, 12.288 MHz from PLL outclk_0.
- rst_n  in  1  reset, asynchronous, active-low.
- pll_locked  in  1  PLL locked, asynchronous to clk; synchronized internally.
- enable  in  1  software run enable.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  holding register empty.
- s_left  in  DATA_W  left sample, two's complement.
- s_right  in  DATA_W  right sample.
- i2s_bclk  out  1  bit clock.
- i2s_lrck  out  1  word select; 0 = left, 1 = right.
- i2s_dout  out  1  serial data.
- frame_tick  out  1  one-cycle pulse at each frame load.
- underrun  out  1  sticky: a frame loaded with no sample available.

## Operation
- Synchronization: pll_locked passes through a 2-flop synchronizer to give locked_s. Define run = enable & locked_s.
- While run=0:
  - div_cnt, bit_cnt and the shift register are cleared.
  - i2s_bclk, i2s_lrck, i2s_dout and frame_tick are 0.
  - The holding register keeps its contents.
  - underrun is cleared only when enable=0.
- Counters:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - i2s_bclk = (div_cnt ≥ BCLK_DIV/2), registered.
  - bit_cnt counts 0..2*SLOT_W-1 and advances when div_cnt wraps, which is the BCLK falling edge.
  - i2s_lrck = (bit_cnt ≥ SLOT_W).
- Frame load happens when bit_cnt wraps to 0, and also on the first cycle after run rises.
  - If the holding register is full: shift register ← {s_left, s_right}, and full is cleared.
  - If it is empty: the shift register is loaded with zeros and underrun is set.
  - frame_tick pulses in either case.
- Data position: within a slot, position k=0 drives 0. Positions k=1..DATA_W drive bit DATA_W-k, so the MSB appears one BCLK after the LRCK edge. Positions k>DATA_W drive 0.
- Handshake:
  - s_ready = ~full.
  - A transfer occurs when s_valid & s_ready; it sets full and captures both channels.
  - Transfers are accepted even while run=0, so the buffer can be pre-filled.
- Simultaneous transfer and frame load with the buffer empty: the load sees empty, so zeros are sent and underrun is set. The new sample is held for the next frame.

## Timing
- Reset values: i2s_bclk=0, i2s_lrck=0, i2s_dout=0, frame_tick=0, underrun=0, s_ready=1 (full=0).
- All outputs except s_ready are registered. s_ready is a direct decode of the full flop.
- Lock-to-start: 2 cycles of synchronizer delay, then counters start at 0 and the frame load occurs on the first run cycle.
- Frame period: 2*SLOT_W*BCLK_DIV = 256 clk cycles, giving 48.0005 kHz at 12.288135 MHz.
- Data changes on the BCLK falling edge; the codec samples on the rising edge.
- MSB latency from frame_tick: one BCLK period (BCLK_DIV cycles).
- Loss of lock mid-frame:
  - Outputs go idle 2–3 cycles after pll_locked falls.
  - The partial frame is discarded.
  - On relock, output restarts at bit_cnt=0 with the held sample, if present.

## Configuration
- Macro AUDIO_I2S_TX_UNDERRUN_CNT_EN.
- Defined: adds output underrun_cnt, out, 16 bits.
  - Increments once per underrun frame load and saturates at 16'hFFFF.
  - Cleared while enable=0; reset value 0.
- Undefined: no counter and no port; only the sticky underrun flag exists.

## Structure
- Package audioplay_audio_pkg holds:
  - constants AUDIO_DATA_W=24, AUDIO_SLOT_W=32, AUDIO_BCLK_DIV=4;
  - typedef audio_sample_t (logic [23:0]).
- Sub-module audioplay_sync2 is the generic 2-flop synchronizer with async active-low reset, used for pll_locked.

## Test plan
- Reset: hold rst_n=0 with s_valid=1 → bclk, lrck, dout, frame_tick and underrun are 0 and s_ready=1. After release, the first sample is accepted and s_ready drops.
- Normal play:
  - Stimulus: pre-fill L=24'hA5A5A5, R=24'h5A5A5A, then assert enable and pll_locked.
  - Required: dout on rising BCLK edges reproduces 0,A5A5A5,0×7 then 0,5A5A5A,0×7; lrck period is 256 cycles.
- Starvation: enable with no samples → dout stays 0 and underrun=1 after the first frame_tick. With AUDIO_I2S_TX_UNDERRUN_CNT_EN, underrun_cnt=4 after 4 frames.
- Back-pressure: s_valid held at 1 with incrementing data → exactly one transfer per 256 cycles, each in the cycle after frame_tick. No sample is skipped or duplicated.
- Lock loss: drop pll_locked at bit_cnt=40 → outputs are 0 within 3 cycles. Relocking restarts lrck low at bit 0 and plays the held sample.
- Boundary race: with the buffer empty, present s_valid in the frame-load cycle → that frame is zeros with underrun set, and the sample plays in the next frame.
